// File: rtl/ahb_master.sv
// ahb_master: single-channel AHB3-Lite master.
// Turns one local command into a SINGLE/INCR4/WRAP4/INCR8/INCR16 transfer.
// Ports:
//   HCLK, HRESETn (sync, active-low)
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_size/cmd_burst: command in
//   wdata/wdata_ack: write beat source, ack pulses after each capture
//   rd_data/rd_valid: read beats; done/err: end-of-command status
//   HADDR/HTRANS/HBURST/HWRITE/HSIZE/HWDATA/parityBits: bus outputs
//   HRDATA/HREADY/HRESP: bus inputs
// Optional: AHB_MASTER_ERRINJ_EN adds inj_err, inverting parityBits[0]
// of the write beat captured while it is high.
module ahb_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic [2:0]            cmd_burst,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wdata_ack,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  done,
    output logic                  err,
`ifdef AHB_MASTER_ERRINJ_EN
    input  logic                  inj_err,
`endif
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic [2:0]            HBURST,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [DATA_WIDTH-1:0] HWDATA,
    output logic [15:0]           parityBits,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_BURST,
        S_LAST,
        S_ERR,
        S_DONE
    } state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    state_t state, next_state;

    logic [4:0]            cnt, cnt_d;
    logic [4:0]            cmd_beats;
    logic                  burst_ok, is_incr, crosses, cmd_ok;
    logic [10:0]           span;
    logic                  accept, data_ph, addr_done, inj;
    logic [ADDR_WIDTH-1:0] step, wrap_mask, addr_inc, addr_next;

    logic [ADDR_WIDTH-1:0] haddr_d;
    logic [1:0]            htrans_d;
    logic [2:0]            hburst_d, hsize_d;
    logic                  hwrite_d;
    logic [DATA_WIDTH-1:0] hwdata_d, rd_data_d;
    logic [15:0]           par_d;
    logic                  cmd_ready_d, wdata_ack_d, rd_valid_d;
    logic                  done_d, err_d;

`ifdef AHB_MASTER_ERRINJ_EN
    assign inj = inj_err;
`else
    assign inj = 1'b0;
`endif

    function automatic logic [15:0] pair_parity(input logic [31:0] d);
        logic [15:0] p;
        for (int i = 0; i < 16; i++) begin
            p[i] = d[2*i+1] ^ d[2*i];
        end
        return p;
    endfunction

    // Command legality; INCR bursts may not run past a 1 KB boundary.
    always_comb begin
        burst_ok  = 1'b1;
        is_incr   = 1'b0;
        cmd_beats = 5'd1;
        unique case (cmd_burst)
            3'b000: cmd_beats = 5'd1;
            3'b010: cmd_beats = 5'd4;
            3'b011: begin cmd_beats = 5'd4;  is_incr = 1'b1; end
            3'b101: begin cmd_beats = 5'd8;  is_incr = 1'b1; end
            3'b111: begin cmd_beats = 5'd16; is_incr = 1'b1; end
            default: burst_ok = 1'b0;
        endcase
        span    = 11'(cmd_beats) << cmd_size[1:0];
        crosses = is_incr &&
                  (({1'b0, cmd_addr[9:0]} + span) > 11'd1024);
        cmd_ok  = burst_ok && (cmd_size <= 3'd2) && !crosses;
    end

    // WRAP4 keeps the bits above log2(4*step) and wraps the rest.
    always_comb begin
        step      = ADDR_WIDTH'(1) << HSIZE[1:0];
        wrap_mask = (step << 2) - ADDR_WIDTH'(1);
        addr_inc  = HADDR + step;
        if (HBURST == 3'b010)
            addr_next = (HADDR & ~wrap_mask) | (addr_inc & wrap_mask);
        else
            addr_next = addr_inc;
    end

    assign accept  = cmd_valid && cmd_ready;
    assign data_ph = (state == S_BURST) || (state == S_LAST);
    // In S_ADDR no data phase is outstanding, so HRESP is not looked at.
    assign addr_done = HREADY &&
                       ((state == S_ADDR) ||
                        (state == S_BURST && !HRESP));

    always_ff @(posedge HCLK) begin
        if (!HRESETn) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:
                if (accept) next_state = cmd_ok ? S_ADDR : S_DONE;
            S_ADDR:
                if (HREADY)
                    next_state = (cnt == 5'd1) ? S_LAST : S_BURST;
            S_BURST:
                if (HRESP)
                    next_state = HREADY ? S_DONE : S_ERR;
                else if (HREADY)
                    next_state = (cnt == 5'd1) ? S_LAST : S_BURST;
            S_LAST:
                if (HRESP)
                    next_state = HREADY ? S_DONE : S_ERR;
                else if (HREADY)
                    next_state = S_DONE;
            S_ERR:
                if (HREADY) next_state = S_DONE;
            S_DONE:
                next_state = S_IDLE;
            default:
                next_state = S_IDLE;
        endcase
    end

    // All outputs are registered; this block computes their next values.
    always_comb begin
        haddr_d   = HADDR;
        hburst_d  = HBURST;
        hsize_d   = HSIZE;
        hwrite_d  = HWRITE;
        hwdata_d  = HWDATA;
        par_d     = parityBits;
        rd_data_d = rd_data;
        cnt_d     = cnt;

        unique case (next_state)
            S_ADDR:  htrans_d = TR_NONSEQ;
            S_BURST: htrans_d = TR_SEQ;
            default: htrans_d = TR_IDLE;
        endcase

        cmd_ready_d = (next_state == S_IDLE);
        done_d      = (next_state == S_DONE);
        // Reaching S_DONE from S_IDLE means the command was rejected.
        err_d       = done_d &&
                      ((state == S_IDLE) || (state == S_ERR) || HRESP);
        rd_valid_d  = !HWRITE && data_ph && HREADY && !HRESP;
        wdata_ack_d = HWRITE && addr_done;

        if (accept && cmd_ok) begin
            haddr_d  = cmd_addr;
            hburst_d = cmd_burst;
            hsize_d  = cmd_size;
            hwrite_d = cmd_write;
            cnt_d    = cmd_beats;
        end

        if (addr_done) begin
            cnt_d = cnt - 5'd1;
            if (cnt != 5'd1) haddr_d = addr_next;
            if (HWRITE) begin
                hwdata_d = wdata;
                par_d    = pair_parity(32'(wdata)) ^ {15'd0, inj};
            end
        end

        if (rd_valid_d) rd_data_d = HRDATA;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            HADDR      <= '0;
            HTRANS     <= TR_IDLE;
            HBURST     <= 3'b000;
            HSIZE      <= 3'b000;
            HWRITE     <= 1'b0;
            HWDATA     <= '0;
            parityBits <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            wdata_ack  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cmd_ready  <= 1'b0;
            cnt        <= '0;
        end else begin
            HADDR      <= haddr_d;
            HTRANS     <= htrans_d;
            HBURST     <= hburst_d;
            HSIZE      <= hsize_d;
            HWRITE     <= hwrite_d;
            HWDATA     <= hwdata_d;
            parityBits <= par_d;
            rd_data    <= rd_data_d;
            rd_valid   <= rd_valid_d;
            wdata_ack  <= wdata_ack_d;
            done       <= done_d;
            err        <= err_d;
            cmd_ready  <= cmd_ready_d;
            cnt        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ahb_master.sv
// tb_ahb_master: directed self-checking bench for ahb_master.
// Steps run once, in order, from a single initial block.
module tb_ahb_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size, cmd_burst;
    logic [31:0] wdata, rd_data, HADDR, HWDATA, HRDATA;
    logic        wdata_ack, rd_valid, done, err;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST, HSIZE;
    logic        HWRITE, HREADY, HRESP;
    logic [15:0] parityBits;
`ifdef AHB_MASTER_ERRINJ_EN
    logic        inj_err;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] wrap_a [4];

    always #5 HCLK = ~HCLK;

    ahb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_size   (cmd_size),
        .cmd_burst  (cmd_burst),
        .wdata      (wdata),
        .wdata_ack  (wdata_ack),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .done       (done),
        .err        (err),
`ifdef AHB_MASTER_ERRINJ_EN
        .inj_err    (inj_err),
`endif
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HBURST     (HBURST),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HWDATA     (HWDATA),
        .parityBits (parityBits),
        .HRDATA     (HRDATA),
        .HREADY     (HREADY),
        .HRESP      (HRESP)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    // Present a command for one edge; returns in the first bus cycle.
    task automatic issue(input logic w, input logic [31:0] a,
                         input logic [2:0] s, input logic [2:0] b);
        cmd_write = w;
        cmd_addr  = a;
        cmd_size  = s;
        cmd_burst = b;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wrap_a[0] = 32'h38;
        wrap_a[1] = 32'h3C;
        wrap_a[2] = 32'h30;
        wrap_a[3] = 32'h34;
        HRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_size  = '0;
        cmd_burst = '0;
        wdata     = '0;
        HRDATA    = '0;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
`ifdef AHB_MASTER_ERRINJ_EN
        inj_err   = 1'b0;
`endif

        // Reset state
        tick();
        tick();
        chk("rst_htrans", HTRANS, 0);
        chk("rst_haddr", HADDR, 0);
        chk("rst_hwrite", HWRITE, 0);
        chk("rst_hsize", HSIZE, 0);
        chk("rst_hburst", HBURST, 0);
        chk("rst_hwdata", HWDATA, 0);
        chk("rst_parity", parityBits, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wack", wdata_ack, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", cmd_ready, 0);
        HRESETn = 1'b1;
        tick();
        chk("ready_after_rst", cmd_ready, 1);

        // SINGLE word write
        wdata = 32'hA5A55A5A;
        issue(1'b1, 32'h10, 3'b010, 3'b000);
        chk("single_htrans", HTRANS, 2'b10);
        chk("single_haddr", HADDR, 32'h10);
        chk("single_hwrite", HWRITE, 1);
        chk("single_ready", cmd_ready, 0);
        tick();
        chk("single_idle", HTRANS, 2'b00);
        chk("single_hwdata", HWDATA, 32'hA5A55A5A);
        chk("single_parity", parityBits, 16'hFFFF);
        chk("single_wack", wdata_ack, 1);
        tick();
        chk("single_done", done, 1);
        chk("single_err", err, 0);
        chk("single_wack_off", wdata_ack, 0);
        tick();
        chk("single_ready_back", cmd_ready, 1);
        chk("single_done_off", done, 0);

        // INCR4 word read, zero wait
        issue(1'b0, 32'h100, 3'b010, 3'b011);
        for (int c = 1; c <= 5; c++) begin
            if (c <= 4) begin
                chk("incr4_haddr", HADDR, 32'h100 + 4 * (c - 1));
                chk("incr4_htrans", HTRANS, (c == 1) ? 2'b10 : 2'b11);
            end else begin
                chk("incr4_last_idle", HTRANS, 2'b00);
            end
            chk("incr4_rvalid", rd_valid, (c >= 3) ? 1 : 0);
            if (c >= 3) chk("incr4_rdata", rd_data, c - 2);
            if (c >= 2) HRDATA = c - 1;
            tick();
        end
        chk("incr4_rvalid4", rd_valid, 1);
        chk("incr4_rdata4", rd_data, 4);
        chk("incr4_done", done, 1);
        chk("incr4_err", err, 0);
        tick();

        // WRAP4 word write from 0x38
        wdata = 32'h11110000;
        issue(1'b1, 32'h38, 3'b010, 3'b010);
        for (int c = 1; c <= 5; c++) begin
            if (c <= 4) begin
                chk("wrap_haddr", HADDR, wrap_a[c-1]);
                wdata = 32'h11110000 + (c - 1);
            end else begin
                chk("wrap_last_idle", HTRANS, 2'b00);
            end
            if (c >= 2) begin
                chk("wrap_wack", wdata_ack, 1);
                chk("wrap_hwdata", HWDATA, 32'h11110000 + (c - 2));
            end
            if (c == 2) chk("wrap_parity", parityBits, 16'h5500);
            tick();
        end
        chk("wrap_done", done, 1);
        chk("wrap_wack_off", wdata_ack, 0);
        tick();

        // INCR4 read, HREADY low for two cycles on beat 2
        issue(1'b0, 32'h200, 3'b010, 3'b011);
        chk("wait_nonseq", HTRANS, 2'b10);
        tick();
        chk("wait_b2_addr", HADDR, 32'h204);
        HREADY = 1'b0;
        tick();
        chk("wait_hold_addr1", HADDR, 32'h204);
        chk("wait_hold_tr1", HTRANS, 2'b11);
        chk("wait_hold_rv1", rd_valid, 0);
        tick();
        chk("wait_hold_addr2", HADDR, 32'h204);
        chk("wait_hold_tr2", HTRANS, 2'b11);
        HREADY = 1'b1;
        HRDATA = 32'h11;
        tick();
        chk("wait_b3_addr", HADDR, 32'h208);
        chk("wait_rv1", rd_valid, 1);
        chk("wait_rd1", rd_data, 32'h11);
        HRDATA = 32'h22;
        tick();
        chk("wait_b4_addr", HADDR, 32'h20C);
        chk("wait_no_early_done", done, 0);
        HRDATA = 32'h33;
        tick();
        chk("wait_last_idle", HTRANS, 2'b00);
        HRDATA = 32'h44;
        tick();
        chk("wait_done", done, 1);
        chk("wait_rd4", rd_data, 32'h44);
        chk("wait_err", err, 0);
        tick();

        // INCR4 crossing 1 KB at 0x3F8: rejected
        issue(1'b1, 32'h3F8, 3'b010, 3'b011);
        chk("cross_done", done, 1);
        chk("cross_err", err, 1);
        chk("cross_no_nonseq", HTRANS, 2'b00);
        chk("cross_no_wack", wdata_ack, 0);
        tick();
        chk("cross_ready", cmd_ready, 1);
        chk("cross_done_off", done, 0);

        // Illegal size: rejected
        issue(1'b0, 32'h0, 3'b011, 3'b000);
        chk("size_done", done, 1);
        chk("size_err", err, 1);
        chk("size_no_nonseq", HTRANS, 2'b00);
        tick();

        // INCR4 ending exactly at 0x3FF: legal
        issue(1'b0, 32'h3F0, 3'b010, 3'b011);
        chk("edge_nonseq", HTRANS, 2'b10);
        chk("edge_haddr", HADDR, 32'h3F0);
        for (int i = 0; i < 5; i++) tick();
        chk("edge_done", done, 1);
        chk("edge_err", err, 0);
        tick();

        // ERROR response on beat 2
        issue(1'b0, 32'h400, 3'b010, 3'b011);
        tick();
        HRDATA = 32'hAA;
        tick();
        chk("errr_rv1", rd_valid, 1);
        chk("errr_rd1", rd_data, 32'hAA);
        chk("errr_b3_addr", HADDR, 32'h408);
        HRESP  = 1'b1;
        HREADY = 1'b0;
        tick();
        chk("errr_idle", HTRANS, 2'b00);
        chk("errr_no_rv", rd_valid, 0);
        HREADY = 1'b1;
        tick();
        chk("errr_done", done, 1);
        chk("errr_err", err, 1);
        chk("errr_no_rv2", rd_valid, 0);
        chk("errr_idle2", HTRANS, 2'b00);
        HRESP = 1'b0;
        tick();
        chk("errr_ready", cmd_ready, 1);
        chk("errr_idle3", HTRANS, 2'b00);

        // Reset in the middle of a write burst
        wdata = 32'h12345678;
        issue(1'b1, 32'h500, 3'b010, 3'b011);
        tick();
        chk("mrst_seq", HTRANS, 2'b11);
        chk("mrst_hwdata", HWDATA, 32'h12345678);
        HRESETn = 1'b0;
        tick();
        chk("mrst_htrans", HTRANS, 0);
        chk("mrst_haddr", HADDR, 0);
        chk("mrst_hwdata0", HWDATA, 0);
        chk("mrst_parity", parityBits, 0);
        chk("mrst_hwrite", HWRITE, 0);
        chk("mrst_hburst", HBURST, 0);
        chk("mrst_wack", wdata_ack, 0);
        chk("mrst_done", done, 0);
        chk("mrst_ready", cmd_ready, 0);
        HRESETn = 1'b1;
        tick();
        chk("mrst_ready_back", cmd_ready, 1);
        chk("mrst_no_done", done, 0);

`ifdef AHB_MASTER_ERRINJ_EN
        // Corrupted parity on a write beat, slave answers ERROR
        wdata   = 32'h00000003;
        inj_err = 1'b1;
        issue(1'b1, 32'h20, 3'b010, 3'b000);
        tick();
        inj_err = 1'b0;
        chk("inj_hwdata", HWDATA, 32'h3);
        chk("inj_parity", parityBits, 16'h0001);
        HRESP  = 1'b1;
        HREADY = 1'b0;
        tick();
        chk("inj_idle", HTRANS, 2'b00);
        HREADY = 1'b1;
        tick();
        chk("inj_done", done, 1);
        chk("inj_err", err, 1);
        HRESP = 1'b0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
